// File: rtl/i2c_dac_target_pkg.sv
// Shared types and constants for the I2C DAC fast-write target.
package i2c_dac_target_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  localparam int CH_W      = 12;
  localparam int NUM_CH    = 4;
  localparam int IDX_W     = 2;

  localparam logic [4:0] CMD_PREFIX = 5'b01000;

  localparam logic [IDX_W-1:0] CH_A = 2'd0;
  localparam logic [IDX_W-1:0] CH_B = 2'd1;
  localparam logic [IDX_W-1:0] CH_C = 2'd2;
  localparam logic [IDX_W-1:0] CH_D = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CMD,
    ST_CMD_ACK,
    ST_HI,
    ST_HI_ACK,
    ST_LO,
    ST_LO_ACK,
    ST_IGNORE
  } state_t;

  // A STOP/START landing here leaves a channel write half-done.
  function automatic logic is_partial_write(input state_t s);
    return (s == ST_CMD_ACK) || (s == ST_HI) || (s == ST_HI_ACK) || (s == ST_LO);
  endfunction

  function automatic state_t ack_next(input state_t s);
    case (s)
      ST_ADDR_ACK: return ST_CMD;
      ST_CMD_ACK:  return ST_HI;
      ST_HI_ACK:   return ST_LO;
      ST_LO_ACK:   return ST_CMD;
      default:     return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one bus line, followed by a rise/fall detector.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Reset to the idle-high bus level so release of reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign line = sync_reg[SYNC_STAGES-1];
  assign rise = line & ~prev_reg;
  assign fall = ~line & prev_reg;

endmodule

// File: rtl/i2c_dac_target.sv
// Write-only I2C target decoding address + repeated {cmd, hi, lo} channel writes
// into four 12-bit DAC channel registers.
module i2c_dac_target
  import i2c_dac_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'b1100000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic [NUM_CH*CH_W-1:0]   ch_values,
  output logic [NUM_CH-1:0]        ch_update,
  output logic                     busy,
  output logic                     frame_err
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (scl_in),
    .line    (scl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (sda_in),
    .line    (sda),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  // SCL must have been high before and after this cycle; a simultaneous
  // SCL edge makes the SDA change plain data.
  logic scl_steady_high;
  logic start_evt;
  logic stop_evt;

  assign scl_steady_high = scl & ~scl_rise & ~scl_fall;
  assign start_evt       = scl_steady_high & sda_fall;
  assign stop_evt        = scl_steady_high & sda_rise;

  state_t                 state_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic [BYTE_W-1:0]      shift_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [3:0]             hi_reg;
  logic [CH_W-1:0]        ch_reg [NUM_CH];
  logic                   sda_oe_reg;
  logic                   busy_reg;
  logic                   frame_err_reg;
  logic [NUM_CH-1:0]      ch_update_reg;

  logic [BYTE_W-1:0]      byte_next;
  logic                   byte_last_bit;

  assign byte_next     = {shift_reg[BYTE_W-2:0], sda};
  assign byte_last_bit = (bit_cnt_reg == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      idx_reg       <= '0;
      hi_reg        <= '0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      ch_update_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_reg[i] <= '0;
      end
    end else begin
      ch_update_reg <= '0;
      frame_err_reg <= 1'b0;

      if (start_evt || stop_evt) begin
        state_reg   <= start_evt ? ST_ADDR : ST_IDLE;
        bit_cnt_reg <= '0;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b0;
        if (is_partial_write(state_reg)) begin
          frame_err_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          ST_ADDR, ST_CMD, ST_HI, ST_LO: begin
            if (scl_rise) begin
              shift_reg   <= byte_next;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (byte_last_bit) begin
                case (state_reg)
                  ST_ADDR: begin
                    if (byte_next[7:1] == I2C_ADDR && !byte_next[0]) begin
                      state_reg <= ST_ADDR_ACK;
                      busy_reg  <= 1'b1;
                    end else begin
                      state_reg <= ST_IGNORE;
                    end
                  end
                  ST_CMD: begin
                    if (byte_next[7:3] == CMD_PREFIX && !byte_next[0]) begin
                      idx_reg   <= byte_next[2:1];
                      state_reg <= ST_CMD_ACK;
                    end else begin
                      frame_err_reg <= 1'b1;
                      state_reg     <= ST_IGNORE;
                    end
                  end
                  ST_HI: begin
                    hi_reg    <= byte_next[3:0];
                    state_reg <= ST_HI_ACK;
                  end
                  ST_LO: begin
                    ch_reg[idx_reg]        <= {hi_reg, byte_next};
                    ch_update_reg[idx_reg] <= 1'b1;
                    state_reg              <= ST_LO_ACK;
                  end
                  default: ;
                endcase
              end
            end
          end

          // First SCL fall after the 8th bit starts the ACK pulse, the next one ends it.
          ST_ADDR_ACK, ST_CMD_ACK, ST_HI_ACK, ST_LO_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_reg) begin
                sda_oe_reg <= 1'b1;
              end else begin
                sda_oe_reg  <= 1'b0;
                bit_cnt_reg <= '0;
                state_reg   <= ack_next(state_reg);
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_out
      assign ch_values[gi*CH_W +: CH_W] = ch_reg[gi];
    end
  endgenerate

  assign sda_oe    = sda_oe_reg;
  assign ch_update = ch_update_reg;
  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_i2c_dac_target.sv
// Table-driven bench for i2c_dac_target: a bit-banged I2C controller drives
// directed transactions and checks ACKs, channel values and pulse counts.
module tb_i2c_dac_target;
  import i2c_dac_target_pkg::*;

  localparam int Q = 8;

  typedef struct {
    logic [63:0] bytes;
    int          nbytes;
    logic [7:0]  exp_ack;
    logic        exp_busy;
    logic [47:0] exp_ch;
    int          exp_upd;
    logic [3:0]  exp_first;
    logic [3:0]  exp_last;
    int          exp_ferr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [47:0] ch_values;
  logic [3:0]  ch_update;
  logic        busy;
  logic        frame_err;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_dac_target #(.I2C_ADDR(7'b1100000), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .ch_values (ch_values),
    .ch_update (ch_update),
    .busy      (busy),
    .frame_err (frame_err)
  );

  int         upd_cnt = 0;
  int         ferr_cnt = 0;
  int         overlap_cnt = 0;
  logic [3:0] upd_log [256];

  always @(negedge clk) begin
    if (ch_update != 4'b0) begin
      upd_log[upd_cnt % 256] <= ch_update;
      upd_cnt <= upd_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (frame_err && ch_update != 4'b0) overlap_cnt <= overlap_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] get_ch(input logic [47:0] v, input logic [1:0] c);
    return v[c*12 +: 12];
  endfunction

  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; waitq();
    scl = 1'b1;   waitq();
    sda_m = 1'b0; waitq();
    scl = 1'b0;   waitq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; waitq();
    scl = 1'b1;   waitq();
    sda_m = 1'b1; waitq();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; waitq();
      scl = 1'b1;   waitq();
      scl = 1'b0;   waitq();
    end
  endtask

  task automatic ack_clock(output logic ack);
    sda_m = 1'b1; waitq();
    scl = 1'b1;   waitq();
    ack = ~sda_in;
    scl = 1'b0;   waitq();
  endtask

  task automatic xfer(input logic [7:0] b, output logic ack);
    send_bits(b);
    ack_clock(ack);
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int upd0, ferr0;
    logic [7:0] acks;
    logic a;
    upd0 = upd_cnt;
    ferr0 = ferr_cnt;
    acks = '0;
    bus_start();
    for (int i = 0; i < v.nbytes; i++) begin
      xfer(v.bytes[63-8*i -: 8], a);
      acks[7-i] = a;
    end
    chk($sformatf("t%0d busy_mid", id), busy, v.exp_busy);
    bus_stop();
    repeat (4) @(negedge clk);
    $display("txn %0d: acks=%b ch_values=%h upd=%0d ferr=%0d busy=%b", id, acks,
             ch_values, upd_cnt - upd0, ferr_cnt - ferr0, busy);
    chk($sformatf("t%0d acks", id), acks, v.exp_ack);
    chk($sformatf("t%0d busy_after_stop", id), busy, 1'b0);
    chk($sformatf("t%0d ch_values", id), ch_values, v.exp_ch);
    chk($sformatf("t%0d upd_count", id), upd_cnt - upd0, v.exp_upd);
    chk($sformatf("t%0d ferr_count", id), ferr_cnt - ferr0, v.exp_ferr);
    if (v.exp_upd > 0) begin
      chk($sformatf("t%0d upd_first", id), upd_log[upd0 % 256], v.exp_first);
      chk($sformatf("t%0d upd_last", id), upd_log[(upd_cnt - 1) % 256], v.exp_last);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int upd0, ferr0;
    logic [7:0] acks;
    logic a;

    vecs[0] = '{bytes:64'hC0_42_03_A5_00_00_00_00, nbytes:4, exp_ack:8'b1111_0000, exp_busy:1'b1,
                exp_ch:48'h000_000_3A5_000, exp_upd:1, exp_first:4'b0010, exp_last:4'b0010, exp_ferr:0};
    vecs[1] = '{bytes:64'hC0_44_0F_FF_46_00_00_00, nbytes:7, exp_ack:8'b1111_1110, exp_busy:1'b1,
                exp_ch:48'h000_FFF_3A5_000, exp_upd:2, exp_first:4'b0100, exp_last:4'b1000, exp_ferr:0};
    vecs[2] = '{bytes:64'hC2_00_00_00_00_00_00_00, nbytes:1, exp_ack:8'b0000_0000, exp_busy:1'b0,
                exp_ch:48'h000_FFF_3A5_000, exp_upd:0, exp_first:4'b0, exp_last:4'b0, exp_ferr:0};
    vecs[3] = '{bytes:64'hC1_00_00_00_00_00_00_00, nbytes:1, exp_ack:8'b0000_0000, exp_busy:1'b0,
                exp_ch:48'h000_FFF_3A5_000, exp_upd:0, exp_first:4'b0, exp_last:4'b0, exp_ferr:0};
    vecs[4] = '{bytes:64'hC0_43_0F_FF_00_00_00_00, nbytes:4, exp_ack:8'b1000_0000, exp_busy:1'b1,
                exp_ch:48'h000_FFF_3A5_000, exp_upd:0, exp_first:4'b0, exp_last:4'b0, exp_ferr:1};
    vecs[5] = '{bytes:64'hC0_42_01_23_00_00_00_00, nbytes:4, exp_ack:8'b1111_0000, exp_busy:1'b1,
                exp_ch:48'h000_FFF_123_000, exp_upd:1, exp_first:4'b0010, exp_last:4'b0010, exp_ferr:0};
    vecs[6] = '{bytes:64'hC0_40_0A_BC_00_00_00_00, nbytes:4, exp_ack:8'b1111_0000, exp_busy:1'b1,
                exp_ch:48'h000_FFF_123_ABC, exp_upd:1, exp_first:4'b0001, exp_last:4'b0001, exp_ferr:0};
    vecs[7] = '{bytes:64'hC0_40_05_00_00_00_00_00, nbytes:3, exp_ack:8'b1110_0000, exp_busy:1'b1,
                exp_ch:48'h000_FFF_123_ABC, exp_upd:0, exp_first:4'b0, exp_last:4'b0, exp_ferr:1};

    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset sda_oe", sda_oe, 1'b0);
    chk("reset ch_values", ch_values, 48'h0);
    chk("reset ch_update", ch_update, 4'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);

    for (int t = 0; t < 8; t++) run_txn(t, vecs[t]);

    // Partial write to A cut by a repeated START; the following write commits.
    upd0 = upd_cnt;
    ferr0 = ferr_cnt;
    acks = '0;
    bus_start();
    xfer(8'hC0, a); acks[7] = a;
    xfer(8'h40, a); acks[6] = a;
    xfer(8'h05, a); acks[5] = a;
    bus_start();
    xfer(8'hC0, a); acks[4] = a;
    xfer(8'h40, a); acks[3] = a;
    xfer(8'h07, a); acks[2] = a;
    xfer(8'h89, a); acks[1] = a;
    bus_stop();
    repeat (4) @(negedge clk);
    $display("txn rstart: acks=%b ch_values=%h upd=%0d ferr=%0d", acks, ch_values,
             upd_cnt - upd0, ferr_cnt - ferr0);
    chk("rstart acks", acks, 8'b1111_1110);
    chk("rstart ferr_count", ferr_cnt - ferr0, 1);
    chk("rstart upd_count", upd_cnt - upd0, 1);
    chk("rstart upd_mask", upd_log[upd0 % 256], 4'b0001);
    chk("rstart ch_a", get_ch(ch_values, CH_A), 12'h789);
    chk("rstart ch_b", get_ch(ch_values, CH_B), 12'h123);
    chk("rstart ch_c", get_ch(ch_values, CH_C), 12'hFFF);
    chk("rstart ch_d", get_ch(ch_values, CH_D), 12'h000);

    // Reset while the target drives the ACK for the HI byte.
    bus_start();
    xfer(8'hC0, a);
    xfer(8'h42, a);
    send_bits(8'h0F);
    sda_m = 1'b1;
    waitq();
    chk("hi_ack sda_oe", sda_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset_mid: sda_oe=%b ch_values=%h busy=%b", sda_oe, ch_values, busy);
    chk("rst_mid sda_oe", sda_oe, 1'b0);
    chk("rst_mid ch_values", ch_values, 48'h0);
    chk("rst_mid busy", busy, 1'b0);
    scl = 1'b1; waitq();
    scl = 1'b0; waitq();
    bus_stop();
    repeat (4) @(negedge clk);
    run_txn(8, '{bytes:64'hC0_46_01_02_00_00_00_00, nbytes:4, exp_ack:8'b1111_0000, exp_busy:1'b1,
                 exp_ch:48'h102_000_000_000, exp_upd:1, exp_first:4'b1000, exp_last:4'b1000, exp_ferr:0});

    chk("no frame_err/ch_update overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
